// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage and its data memory.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEFAULT_DEPTH       = 64;
  localparam int DEFAULT_BASE_ADDR   = 1024;
  localparam int DEFAULT_WAIT_CYCLES = 4;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The counter is loaded with WAIT_CYCLES-1, so it needs clog2(WAIT_CYCLES) bits.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Data memory for the MEM stage: DEPTH x n words, synchronous write, asynchronous read.
// Contents are never reset.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int  n     = 32,
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [n-1:0]  wdata,
  output logic [n-1:0]  rdata
);

  logic [n-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Combinational read returns the pre-write contents at a same-edge write.
  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage with MEM/WB output register. Define MEM_STAGE_WAIT_EN to add
// the IDLE/WAIT stall FSM; otherwise every access completes at the next edge.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int  n           = 32,
  parameter int  DEPTH       = DEFAULT_DEPTH,
  parameter int  BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int  WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  localparam int AW          = addr_width(DEPTH),
  localparam int CW          = cnt_width(WAIT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          WB_EN_in,
  input  logic          MEM_R_EN_in,
  input  logic          MEM_W_EN_in,
  input  logic [n-1:0]  ALU_Res_in,
  input  logic [n-1:0]  Val_Rm_in,
  input  logic [3:0]    Dest_in,
  output logic          WB_EN_out,
  output logic          MEM_R_EN_out,
  output logic [n-1:0]  ALU_Res_out,
  output logic [n-1:0]  Mem_data_out,
  output logic [3:0]    Dest_out,
  output logic          ready,
  output logic          dbg_state,
  output logic [CW-1:0] dbg_cnt
);

  logic [n-1:0]  offset;
  logic [AW-1:0] mem_addr;
  logic [n-1:0]  rd_data;
  logic          mem_we;

  // Out-of-range addresses wrap onto the array instead of faulting.
  assign offset   = ALU_Res_in - n'(BASE_ADDR);
  assign mem_addr = AW'((offset >> 2) % n'(DEPTH));

  data_memory #(
    .n     (n),
    .DEPTH (DEPTH)
  ) u_data_memory (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (Val_Rm_in),
    .rdata (rd_data)
  );

`ifdef MEM_STAGE_WAIT_EN
  state_t        state;
  logic [CW-1:0] cnt;
  logic          mem_op;

  assign mem_op = MEM_R_EN_in | MEM_W_EN_in;

  // ready is the access strobe: the upstream pipeline only advances when it is high.
  assign ready  = (state == IDLE) ? !mem_op : (cnt == '0);
  assign mem_we = (state == WAIT) && (cnt == '0) && MEM_W_EN_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state <= WAIT;
            cnt   <= CW'(WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_cnt   = cnt;
`else
  assign ready     = 1'b1;
  assign mem_we    = MEM_W_EN_in;
  assign dbg_state = 1'b0;
  assign dbg_cnt   = '0;
`endif

  // MEM/WB register: real capture when ready, otherwise a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_EN_out    <= 1'b0;
      MEM_R_EN_out <= 1'b0;
      ALU_Res_out  <= '0;
      Mem_data_out <= '0;
      Dest_out     <= '0;
    end else if (ready) begin
      WB_EN_out    <= WB_EN_in;
      MEM_R_EN_out <= MEM_R_EN_in & ~MEM_W_EN_in;
      ALU_Res_out  <= ALU_Res_in;
      Mem_data_out <= rd_data;
      Dest_out     <= Dest_in;
    end else begin
      WB_EN_out    <= 1'b0;
      MEM_R_EN_out <= 1'b0;
      ALU_Res_out  <= '0;
      Mem_data_out <= '0;
      Dest_out     <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage; follows MEM_STAGE_WAIT_EN to pick the
// expected stall length.
module tb_mem_stage;

`ifdef MEM_STAGE_WAIT_EN
  localparam int STALL = 4;
`else
  localparam int STALL = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        WB_EN_in = 1'b0, MEM_R_EN_in = 1'b0, MEM_W_EN_in = 1'b0;
  logic [31:0] ALU_Res_in = '0, Val_Rm_in = '0;
  logic [3:0]  Dest_in = '0;
  logic        WB_EN_out, MEM_R_EN_out, ready, dbg_state;
  logic [31:0] ALU_Res_out, Mem_data_out;
  logic [3:0]  Dest_out;
  logic [1:0]  dbg_cnt;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .WB_EN_in     (WB_EN_in),
    .MEM_R_EN_in  (MEM_R_EN_in),
    .MEM_W_EN_in  (MEM_W_EN_in),
    .ALU_Res_in   (ALU_Res_in),
    .Val_Rm_in    (Val_Rm_in),
    .Dest_in      (Dest_in),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_EN_out (MEM_R_EN_out),
    .ALU_Res_out  (ALU_Res_out),
    .Mem_data_out (Mem_data_out),
    .Dest_out     (Dest_out),
    .ready        (ready),
    .dbg_state    (dbg_state),
    .dbg_cnt      (dbg_cnt)
  );

  // scoreboard
  typedef struct {
    string       name;
    logic        wb;
    logic        mr;
    logic [31:0] alu;
    logic [3:0]  dest;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: ready seen before an edge means that edge captures an instruction.
  initial begin
    logic r_s, rst_s;
    exp_t e;
    forever begin
      @(negedge clk);
      r_s   = ready;
      rst_s = rst;
      @(posedge clk);
      #1;
      if (!rst_s && !rst) begin
        if (r_s) begin
          if (exp_q.size() == 0) begin
            check("unexpected_capture", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check({e.name, ".WB_EN_out"},    32'(WB_EN_out),    32'(e.wb));
            check({e.name, ".MEM_R_EN_out"}, 32'(MEM_R_EN_out), 32'(e.mr));
            check({e.name, ".ALU_Res_out"},  ALU_Res_out,       e.alu);
            check({e.name, ".Dest_out"},     32'(Dest_out),     32'(e.dest));
            if (e.chk_data) check({e.name, ".Mem_data_out"}, Mem_data_out, e.data);
          end
        end else begin
          check("bubble", 32'({WB_EN_out, MEM_R_EN_out}), 32'd0);
        end
      end
    end
  end

  // Driver: call just after a posedge; returns #1 after the capturing edge.
  task automatic issue(input string name, input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest,
                       input logic chk_data, input logic [31:0] exp_data);
    exp_t e;
    int stalls;
    WB_EN_in    = wb;
    MEM_R_EN_in = r;
    MEM_W_EN_in = w;
    ALU_Res_in  = alu;
    Val_Rm_in   = val;
    Dest_in     = dest;
    e.name = name; e.wb = wb; e.mr = r & ~w; e.alu = alu; e.dest = dest;
    e.chk_data = chk_data; e.data = exp_data;
    exp_q.push_back(e);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      stalls++;
      if (stalls > 50) break;
    end
    check({name, ".stall_cycles"}, 32'(stalls), (r | w) ? 32'(STALL) : 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name);
    issue(name, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset.WB_EN_out",    32'(WB_EN_out),    32'd0);
    check("reset.MEM_R_EN_out", 32'(MEM_R_EN_out), 32'd0);
    check("reset.ALU_Res_out",  ALU_Res_out,       32'd0);
    check("reset.Mem_data_out", Mem_data_out,      32'd0);
    check("reset.Dest_out",     32'(Dest_out),     32'd0);
    check("reset.ready",        32'(ready),        32'd1);
    check("reset.dbg_state",    32'(dbg_state),    32'd0);
    check("reset.dbg_cnt",      32'(dbg_cnt),      32'd0);
    #1 rst = 1'b0;

    issue("alu_55",      1'b1, 1'b0, 1'b0, 32'h55,   32'h0,        4'd3,  1'b0, 32'h0);
    issue("alu_a5a5",    1'b0, 1'b0, 1'b0, 32'hA5A5, 32'h1234,     4'd15, 1'b0, 32'h0);
    issue("store_1028",  1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0,  1'b0, 32'h0);
    issue("load_1028",   1'b1, 1'b1, 1'b0, 32'd1028, 32'h0,        4'd5,  1'b1, 32'hDEADBEEF);
    idle("idle_after_load");
    issue("store_1280",  1'b0, 1'b0, 1'b1, 32'd1280, 32'h12345678, 4'd0,  1'b0, 32'h0);
    issue("load_1024",   1'b1, 1'b1, 1'b0, 32'd1024, 32'h0,        4'd7,  1'b1, 32'h12345678);
    issue("store_1032",  1'b0, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 4'd0,  1'b0, 32'h0);
    issue("load_1032",   1'b1, 1'b1, 1'b0, 32'd1032, 32'h0,        4'd9,  1'b1, 32'hCAFEF00D);
    issue("rw_1036",     1'b1, 1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 4'd2,  1'b0, 32'h0);
    issue("load_1036",   1'b1, 1'b1, 1'b0, 32'd1036, 32'h0,        4'd4,  1'b1, 32'h0BADF00D);
    issue("store_1020",  1'b0, 1'b0, 1'b1, 32'd1020, 32'h13579BDF, 4'd0,  1'b0, 32'h0);
    issue("load_1276",   1'b1, 1'b1, 1'b0, 32'd1276, 32'h0,        4'd6,  1'b1, 32'h13579BDF);

`ifdef MEM_STAGE_WAIT_EN
    // Store aborted by reset in its second WAIT cycle; the word must keep its old value.
    MEM_W_EN_in = 1'b1;
    ALU_Res_in  = 32'd1028;
    Val_Rm_in   = 32'hFFFF0000;
    repeat (2) @(posedge clk);
    #1;
    check("abort.dbg_state", 32'(dbg_state), 32'd1);
    check("abort.dbg_cnt",   32'(dbg_cnt),   32'd2);
    rst = 1'b1;
    MEM_W_EN_in = 1'b0;
    ALU_Res_in  = 32'd0;
    Val_Rm_in   = 32'd0;
    #1;
    check("abort.dbg_state_rst", 32'(dbg_state),    32'd0);
    check("abort.dbg_cnt_rst",   32'(dbg_cnt),      32'd0);
    check("abort.WB_EN_out",     32'(WB_EN_out),    32'd0);
    check("abort.ALU_Res_out",   ALU_Res_out,       32'd0);
    check("abort.ready",         32'(ready),        32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    issue("load_after_abort", 1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd1, 1'b1, 32'hDEADBEEF);
`endif

    idle("idle_final");
    #2;
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter n, default 32, datapath width.
REQ-002 SHALL have parameter DEPTH, default 64, data-memory words.
REQ-003 SHALL have parameter BASE_ADDR, default 1024, byte address mapped to word 0.
REQ-004 SHALL have parameter WAIT_CYCLES, default 4, stall cycles per memory access (≥1).
REQ-005 SHALL have clk  input  1  single clock, rising edge.
REQ-006 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  input  1 each  control from EXE register.
REQ-008 SHALL have ALU_Res_in  input  n  byte address or ALU result.
REQ-009 SHALL have Val_Rm_in  input  n  store data.
REQ-010 SHALL have Dest_in  input  4  destination register.
REQ-011 SHALL have WB_EN_out, MEM_R_EN_out  output  1 each  registered to WB.
REQ-012 SHALL have ALU_Res_out, Mem_data_out  output  n each  registered to WB.
REQ-013 SHALL have Dest_out  output  4  registered to WB.
REQ-014 SHALL have ready  output  1  combinational; 0 means the whole pipeline upstream freezes.

Function
REQ-015 Word index SHALL be (ALU_Res_in - BASE_ADDR) >> 2, taken modulo DEPTH (out-of-range wraps, no error).
REQ-016 FSM states SHALL be IDLE and WAIT; 2-bit-sufficient down-counter cnt.
REQ-017 Memory op = MEM_R_EN_in | MEM_W_EN_in.
REQ-018 IDLE, no memory op: ready=1; inputs captured into output register at the next edge (latency 1).
REQ-019 IDLE, memory op: ready=0, next state WAIT, cnt <= WAIT_CYCLES-1, output register captures a bubble (WB_EN_out=0, MEM_R_EN_out=0).
REQ-020 WAIT, cnt≠0: ready=0, cnt decrements, bubble captured.
REQ-021 WAIT, cnt==0: ready=1; at that edge write performed (if MEM_W_EN_in), read data and inputs captured into output register, next state IDLE.
REQ-022 A memory op SHALL therefore take WAIT_CYCLES+1 cycles with exactly WAIT_CYCLES cycles of ready=0.
REQ-023 MEM_R_EN_in and MEM_W_EN_in both 1: write SHALL take effect, MEM_R_EN_out SHALL be 0.
REQ-024 Mem_data_out SHALL hold the word read at the access edge; reads see memory contents before a same-edge write.
REQ-025 Inputs SHALL be held stable by upstream while ready=0; the block SHALL sample them only at the access edge.
REQ-026 Back-to-back memory ops SHALL each incur full WAIT_CYCLES; IDLE re-entry after access does not skip the stall.

Reset
REQ-027 rst SHALL asynchronously force state IDLE, cnt 0, all outputs 0 except ready, which follows REQ-018/019 combinationally.
REQ-028 rst asserted during WAIT SHALL abort the access with no memory write.
REQ-029 Data memory contents SHALL NOT be cleared by rst.

Configuration
REQ-030 Macro MEM_STAGE_WAIT_EN: when defined, FSM and stalls per REQ-016..026.
REQ-031 Without MEM_STAGE_WAIT_EN: no FSM, ready tied 1, every access completes at the next edge (latency 1), WAIT_CYCLES ignored.

Structure
REQ-032 A shared package SHALL hold the state typedef (IDLE, WAIT) and default constants DEPTH, BASE_ADDR, WAIT_CYCLES.
REQ-033 Data memory SHALL be a sub-module data_memory (sync write, async read, DEPTH x n).
REQ-034 FSM, counter and MEM/WB output register SHALL be in mem_stage.

Verification
REQ-035 Non-memory op, ALU_Res_in=0x55, Dest_in=3, WB_EN_in=1 -> next cycle ALU_Res_out=0x55, Dest_out=3, WB_EN_out=1, ready stays 1.
REQ-036 Store Val_Rm_in=0xDEADBEEF to 1028 (macro on, WAIT_CYCLES=4) -> ready low 4 cycles, then word 1 = 0xDEADBEEF, WB_EN_out=0 throughout.
REQ-037 Load from 1028 after REQ-036 -> ready low 4 cycles, then Mem_data_out=0xDEADBEEF, MEM_R_EN_out=1 for one cycle.
REQ-038 Store to 1024+4*64=1280 -> word 0 written (wrap).
REQ-039 rst pulsed during 2nd WAIT cycle of a store -> state IDLE, outputs 0, target word unchanged.
REQ-040 Macro off: load from 1028 -> ready never low, Mem_data_out valid next cycle.
